// File: rtl/frame_req_sequencer.sv
// CVM300 FRAME_REQ pulse generator: single frame, fixed-count burst or continuous stream,
// started by a synchronised rising edge of the PC trigger and stoppable by abort.
module frame_req_sequencer #(
    parameter int PULSE_LEN   = 4,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             FSM_Clk,
    input  logic             reset,
    input  logic             trigger,
    input  logic             abort,
    input  logic             mode,
    input  logic [CNT_W-1:0] num_frames,
    input  logic [CNT_W-1:0] interval,
    output logic             FRAME_REQ,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frame_count
);

    // The period counter must reach both the programmed interval and the PULSE_LEN+1 floor.
    localparam int MIN_W = $clog2(PULSE_LEN + 2);
    localparam int PER_W = (CNT_W > MIN_W) ? CNT_W : MIN_W;
    localparam logic [PER_W-1:0] PULSE_LAST   = PER_W'(PULSE_LEN - 1);
    localparam logic [PER_W-1:0] MIN_INTERVAL = PER_W'(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0] COUNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   edge_q, edge_d;
    logic [PER_W-1:0]       period_q, period_d;
    logic [PER_W-1:0]       eff_interval_q, eff_interval_d;
    logic [CNT_W-1:0]       eff_frames_q, eff_frames_d;
    logic [CNT_W-1:0]       frame_count_q, frame_count_d;
    logic                   mode_q, mode_d;
    logic                   abort_pend_q, abort_pend_d;
    logic                   req_q, req_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [PER_W-1:0]       interval_ext;
    logic                   sync_out;

    assign interval_ext = PER_W'(interval);
    assign sync_out     = sync_q[SYNC_STAGES-1];

    // Edge detection is registered so the FSM only ever sees a clean one-cycle start request.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], trigger};
        prev_d = sync_out;
        edge_d = sync_out & ~prev_q;
    end

    always_comb begin
        state_d        = state_q;
        period_d       = period_q;
        eff_interval_d = eff_interval_q;
        eff_frames_d   = eff_frames_q;
        frame_count_d  = frame_count_q;
        mode_d         = mode_q;
        abort_pend_d   = abort_pend_q;
        req_d          = req_q;
        busy_d         = busy_q;
        done_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (edge_q && !abort) begin
                    state_d        = PULSE;
                    req_d          = 1'b1;
                    busy_d         = 1'b1;
                    period_d       = '0;
                    frame_count_d  = CNT_W'(1);
                    abort_pend_d   = 1'b0;
                    mode_d         = mode;
                    eff_frames_d   = (num_frames == '0) ? CNT_W'(1) : num_frames;
                    eff_interval_d = (interval_ext > MIN_INTERVAL) ? interval_ext : MIN_INTERVAL;
                end
            end

            PULSE: begin
                period_d = period_q + PER_W'(1);
                if (period_q == PULSE_LAST) begin
                    req_d = 1'b0;
                    // An abort seen at any point of the pulse only takes effect once it completes.
                    if (abort || abort_pend_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else if (!mode_q && (frame_count_q == eff_frames_q)) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (abort) begin
                    abort_pend_d = 1'b1;
                end
            end

            WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (period_q == (eff_interval_q - PER_W'(1))) begin
                    state_d       = PULSE;
                    req_d         = 1'b1;
                    period_d      = '0;
                    frame_count_d = (frame_count_q == COUNT_MAX) ? frame_count_q
                                                                 : frame_count_q + CNT_W'(1);
                end else begin
                    period_d = period_q + PER_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge FSM_Clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            sync_q         <= '0;
            prev_q         <= 1'b0;
            edge_q         <= 1'b0;
            period_q       <= '0;
            eff_interval_q <= '0;
            eff_frames_q   <= '0;
            frame_count_q  <= '0;
            mode_q         <= 1'b0;
            abort_pend_q   <= 1'b0;
            req_q          <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync_q         <= sync_d;
            prev_q         <= prev_d;
            edge_q         <= edge_d;
            period_q       <= period_d;
            eff_interval_q <= eff_interval_d;
            eff_frames_q   <= eff_frames_d;
            frame_count_q  <= frame_count_d;
            mode_q         <= mode_d;
            abort_pend_q   <= abort_pend_d;
            req_q          <= req_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign FRAME_REQ   = req_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_req_sequencer.sv
// Bench for frame_req_sequencer: table of burst configurations, directed corner sequences,
// and randomised runs compared cycle by cycle against an arithmetic schedule model.
module tb_frame_req_sequencer;

    localparam int PL   = 4;
    localparam int CW   = 6;
    localparam int SS   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic          FSM_Clk = 1'b0;
    logic          reset = 1'b1;
    logic          trigger = 1'b0;
    logic          abort = 1'b0;
    logic          mode = 1'b0;
    logic [CW-1:0] num_frames = '0;
    logic [CW-1:0] interval = '0;
    logic          FRAME_REQ;
    logic          busy;
    logic          done;
    logic [CW-1:0] frame_count;

    int total = 0;
    int bad = 0;

    always #5 FSM_Clk = ~FSM_Clk;

    frame_req_sequencer #(
        .PULSE_LEN  (PL),
        .CNT_W      (CW),
        .SYNC_STAGES(SS)
    ) dut (
        .FSM_Clk    (FSM_Clk),
        .reset      (reset),
        .trigger    (trigger),
        .abort      (abort),
        .mode       (mode),
        .num_frames (num_frames),
        .interval   (interval),
        .FRAME_REQ  (FRAME_REQ),
        .busy       (busy),
        .done       (done),
        .frame_count(frame_count)
    );

    task automatic checkOutput(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0d exp=%0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: a run is a start edge index plus elapsed cycles; pulse phase and
    // frame number come straight from division by the effective interval.
    bit            th [0:7];
    bit            mRun, mAbp, mMode, mInDone;
    int            mRel, mEffI, mEffF;
    bit            expReq, expBusy, expDone;
    int            expFc;

    task automatic modelClear();
        for (int i = 0; i < 8; i++) th[i] = 1'b0;
        mRun = 0; mAbp = 0; mMode = 0; mInDone = 0;
        mRel = 0; mEffI = PL + 1; mEffF = 1;
        expReq = 0; expBusy = 0; expDone = 0; expFc = 0;
    endtask

    task automatic modelStep();
        int  pp;
        int  pf;
        bit  accept;
        for (int i = 7; i > 0; i--) th[i] = th[i-1];
        th[0] = trigger;
        accept = th[SS+1] && !th[SS+2];
        expDone = 0;
        if (mInDone) begin
            mInDone = 0;
        end else if (mRun) begin
            pp = mRel % mEffI;
            pf = mRel / mEffI + 1;
            if (pp < PL) begin
                if (abort) mAbp = 1;
                if (pp == PL - 1) begin
                    if (mAbp) begin
                        mRun = 0;
                    end else if (!mMode && pf == mEffF) begin
                        mRun = 0; expDone = 1; mInDone = 1;
                    end
                end
            end else if (abort) begin
                mRun = 0;
            end
            if (mRun) mRel++;
        end else if (accept && !abort) begin
            mRun = 1; mRel = 0; mAbp = 0; mMode = mode;
            mEffF = (num_frames == 0) ? 1 : int'(num_frames);
            mEffI = (int'(interval) > PL) ? int'(interval) : PL + 1;
        end
        expBusy = mRun;
        if (mRun) begin
            expReq = (mRel % mEffI) < PL;
            expFc  = mRel / mEffI + 1;
            if (expFc > MAXC) expFc = MAXC;
        end else begin
            expReq = 0;
        end
    endtask

    initial begin
        logic [CW+2:0] gotV;
        logic [CW+2:0] expV;
        modelClear();
        forever begin
            @(posedge FSM_Clk or posedge reset);
            if (reset) modelClear();
            else modelStep();
            #1;
            gotV = {FRAME_REQ, busy, done, frame_count};
            expV = {expReq, expBusy, expDone, CW'(expFc)};
            checkOutput("model_cycle", int'(gotV), int'(expV));
        end
    end

    typedef struct {
        bit m;
        int nf;
        int iv;
        int expPulses;
        int expSpacing;
        int expFc;
        int expDones;
    } vec_t;

    task automatic settle(input int n);
        @(negedge FSM_Clk);
        trigger = 1'b0;
        abort   = 1'b0;
        repeat (n) @(negedge FSM_Clk);
    endtask

    task automatic applyStimulus(input vec_t v);
        int lat, rises, dones, sp, minSp, maxSp, minW, maxW, lastRise, width, cyc, idleCnt, orphan;
        bit prevReq;
        @(negedge FSM_Clk);
        trigger = 1'b0; abort = 1'b0;
        mode = v.m; num_frames = CW'(v.nf); interval = CW'(v.iv);
        repeat (5) @(negedge FSM_Clk);
        trigger = 1'b1;
        lat = 0;
        while (!FRAME_REQ && lat < 20) begin
            @(posedge FSM_Clk); #1;
            lat++;
        end
        // rise lands on the (SS+2)-th edge counting the one that first samples trigger
        checkOutput("start_latency", lat, SS + 2);
        checkOutput("busy_at_first_rise", busy, 1);
        rises = 1; lastRise = 0; cyc = 0; width = 1; minSp = 0; maxSp = 0;
        minW = 1000; maxW = 0; dones = 0; prevReq = 1; idleCnt = 0; orphan = 0;
        while (idleCnt < 30 && cyc < 2000) begin
            @(posedge FSM_Clk); #1;
            cyc++;
            if (FRAME_REQ && !prevReq) begin
                rises++;
                sp = cyc - lastRise;
                if (rises == 2 || sp < minSp) minSp = sp;
                if (sp > maxSp) maxSp = sp;
                lastRise = cyc;
                width = 1;
            end else if (FRAME_REQ) begin
                width++;
            end else if (prevReq) begin
                if (width < minW) minW = width;
                if (width > maxW) maxW = width;
            end
            if (done) dones++;
            if (FRAME_REQ && !busy) orphan++;
            if (busy || FRAME_REQ) idleCnt = 0;
            else idleCnt++;
            prevReq = FRAME_REQ;
        end
        checkOutput("vec_finished", int'(cyc < 2000), 1);
        checkOutput("pulse_count", rises, v.expPulses);
        checkOutput("min_spacing", minSp, v.expSpacing);
        checkOutput("max_spacing", maxSp, v.expSpacing);
        checkOutput("min_width", minW, PL);
        checkOutput("max_width", maxW, PL);
        checkOutput("req_without_busy", orphan, 0);
        checkOutput("final_frame_count", frame_count, v.expFc);
        checkOutput("done_pulses", dones, v.expDones);
        @(negedge FSM_Clk);
        trigger = 1'b0;
    endtask

    initial begin
        vec_t vecs [8];
        int   n, cnt, width, rises, dones, busySeen;
        bit   found, prevReq;

        vecs[0] = '{0, 1, 10, 1, 0, 1, 1};
        vecs[1] = '{0, 5, 20, 5, 20, 5, 1};
        vecs[2] = '{0, 0, 2, 1, 0, 1, 1};
        vecs[3] = '{0, 3, 2, 3, 5, 3, 1};
        vecs[4] = '{0, 2, 0, 2, 5, 2, 1};
        vecs[5] = '{0, 3, 5, 3, 5, 3, 1};
        vecs[6] = '{0, 4, 6, 4, 6, 4, 1};
        vecs[7] = '{0, 2, 63, 2, 63, 2, 1};

        @(posedge FSM_Clk); #1;
        checkOutput("reset_req", FRAME_REQ, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_count", frame_count, 0);
        repeat (2) @(negedge FSM_Clk);
        reset = 1'b0;
        settle(4);

        for (int i = 0; i < 8; i++) begin
            $display("[TB] vector %0d: mode=%0d num_frames=%0d interval=%0d", i, vecs[i].m, vecs[i].nf, vecs[i].iv);
            applyStimulus(vecs[i]);
        end

        // continuous stream, abort held from the second cycle of frame 6
        settle(5);
        mode = 1'b1; interval = CW'(8); num_frames = '0;
        @(negedge FSM_Clk);
        trigger = 1'b1;
        found = 0; n = 0;
        while (!found && n < 200) begin
            @(posedge FSM_Clk); #1;
            n++;
            found = FRAME_REQ && (frame_count == CW'(6));
        end
        checkOutput("cont_reached_frame6", found, 1);
        @(negedge FSM_Clk);
        abort = 1'b1; trigger = 1'b0;
        width = 1; n = 0;
        while (n < 10) begin
            @(posedge FSM_Clk); #1;
            n++;
            if (!FRAME_REQ) break;
            width++;
        end
        checkOutput("abort_pulse_width", width, PL);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_frame_count", frame_count, 6);
        rises = 0; dones = 0;
        repeat (20) begin
            @(posedge FSM_Clk); #1;
            if (FRAME_REQ) rises++;
            if (done) dones++;
        end
        checkOutput("abort_no_more_req", rises, 0);
        checkOutput("abort_no_done", dones, 0);

        // trigger toggling during a burst is ignored
        settle(5);
        mode = 1'b0; num_frames = CW'(3); interval = CW'(10);
        @(negedge FSM_Clk);
        trigger = 1'b1;
        rises = 0; dones = 0; prevReq = 0;
        for (int c = 0; c < 90; c++) begin
            @(posedge FSM_Clk); #1;
            if (FRAME_REQ && !prevReq) rises++;
            if (done) dones++;
            prevReq = FRAME_REQ;
            @(negedge FSM_Clk);
            if (c >= 6 && c < 18) trigger = c[1];
            else if (c >= 18) trigger = 1'b0;
        end
        checkOutput("retrigger_pulses", rises, 3);
        checkOutput("retrigger_done", dones, 1);

        // abort coinciding with the cycle the edge reaches the FSM blocks the start
        settle(5);
        num_frames = CW'(1); interval = CW'(10);
        trigger = 1'b1;
        repeat (SS + 1) @(negedge FSM_Clk);
        abort = 1'b1;
        @(negedge FSM_Clk);
        abort = 1'b0;
        busySeen = 0;
        repeat (20) begin
            @(posedge FSM_Clk); #1;
            if (busy || FRAME_REQ) busySeen++;
        end
        checkOutput("abort_precedence", busySeen, 0);

        // earliest restart: edge presented the cycle after DONE
        settle(5);
        num_frames = CW'(1); interval = CW'(10);
        trigger = 1'b1;
        n = 0;
        while (!FRAME_REQ && n < 20) begin
            @(posedge FSM_Clk); #1;
            n++;
        end
        checkOutput("restart_first_rise", FRAME_REQ, 1);
        @(negedge FSM_Clk);
        trigger = 1'b0;
        repeat (2) @(negedge FSM_Clk);
        trigger = 1'b1;
        @(posedge FSM_Clk); #1;
        @(posedge FSM_Clk); #1;
        checkOutput("restart_done", done, 1);
        @(posedge FSM_Clk); #1;
        checkOutput("restart_gap_req", FRAME_REQ, 0);
        @(posedge FSM_Clk); #1;
        checkOutput("restart_second_req", FRAME_REQ, 1);
        checkOutput("restart_second_busy", busy, 1);
        checkOutput("restart_second_count", frame_count, 1);
        settle(20);

        // frame_count saturation in continuous mode (interval clamps to PL+1)
        mode = 1'b1; interval = CW'(3);
        @(negedge FSM_Clk);
        trigger = 1'b1;
        repeat (400) @(posedge FSM_Clk);
        #1;
        checkOutput("sat_count", frame_count, MAXC);
        rises = 0; prevReq = FRAME_REQ;
        repeat (20) begin
            @(posedge FSM_Clk); #1;
            if (FRAME_REQ && !prevReq) rises++;
            prevReq = FRAME_REQ;
        end
        checkOutput("sat_still_pulsing", rises, 4);
        @(negedge FSM_Clk);
        abort = 1'b1; trigger = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            @(posedge FSM_Clk); #1;
            n++;
        end
        checkOutput("sat_stopped", busy, 0);
        checkOutput("sat_count_held", frame_count, MAXC);

        // reset asserted mid-pulse clears outputs without a clock edge
        settle(5);
        mode = 1'b0; num_frames = CW'(5); interval = CW'(20);
        trigger = 1'b1;
        found = 0; n = 0;
        while (!found && n < 100) begin
            @(posedge FSM_Clk); #1;
            n++;
            found = FRAME_REQ && (frame_count == CW'(2));
        end
        checkOutput("reset_run_reached", found, 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_req", FRAME_REQ, 0);
        checkOutput("async_reset_busy", busy, 0);
        checkOutput("async_reset_count", frame_count, 0);
        trigger = 1'b0;
        repeat (3) @(negedge FSM_Clk);
        reset = 1'b0;
        busySeen = 0;
        repeat (40) begin
            @(posedge FSM_Clk); #1;
            if (busy || FRAME_REQ) busySeen++;
        end
        checkOutput("no_pulse_after_reset", busySeen, 0);

        // randomised runs, checked every cycle by the model
        for (int r = 0; r < 30; r++) begin
            settle(5);
            mode       = ($urandom_range(0, 3) == 0);
            num_frames = CW'($urandom_range(0, 5));
            interval   = CW'($urandom_range(0, 14));
            trigger    = 1'b1;
            for (int c = 0; c < 150; c++) begin
                @(negedge FSM_Clk);
                abort = ($urandom_range(0, 29) == 0);
                if ($urandom_range(0, 9) == 0) trigger = ~trigger;
                if ($urandom_range(0, 19) == 0) begin
                    mode       = ~mode;
                    num_frames = CW'($urandom_range(0, 5));
                    interval   = CW'($urandom_range(0, 14));
                end
            end
            abort = 1'b1; trigger = 1'b0;
            repeat (12) @(negedge FSM_Clk);
            abort = 1'b0;
        end
        settle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_req_sequencer.md
# frame_req_sequencer

Parametrised successor to the single-shot camera frame-request pulser: generates CVM300 FRAME_REQ pulses of configurable width, as a single frame, a fixed-count burst, or a continuous stream at a programmable frame interval. It sits beside the SPI and image-FIFO blocks in the top level, driven from FSM_Clk. Its control inputs come from the PC wire-in bus, and its status outputs go back to the PC wire-out bus. A built-in synchroniser makes the PC trigger safe to use across clock domains.

## Interface
- PULSE_LEN, 4: FRAME_REQ high time in FSM_Clk cycles (≥1).
- CNT_W, 16: width of num_frames, interval, frame_count.
- SYNC_STAGES, 2: flops in trigger synchroniser (≥2).

- FSM_Clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- trigger  in  1  asynchronous level (PC domain); rising edge starts a run.
- abort  in  1  synchronous to FSM_Clk, level; stops the run.
- mode  in  1  0 = burst of num_frames, 1 = continuous until abort.
- num_frames  in  CNT_W  frames per burst; 0 treated as 1.
- interval  in  CNT_W  cycles between successive FRAME_REQ rising edges.
- FRAME_REQ  out  1  registered pulse to sensor.
- busy  out  1  high while a run is active.
- done  out  1  one-cycle pulse on normal burst completion.
- frame_count  out  CNT_W  pulses issued in current/last run.

## Operation
- Reset values: FRAME_REQ=0, busy=0, done=0, frame_count=0, state=IDLE, synchroniser and edge-detect flops=0.
- trigger passes SYNC_STAGES flops, then a one-flop edge detector. An edge is (sync & ~prev).
- mode, num_frames and the effective interval are latched on the run start. Input changes mid-run are ignored.
- eff_interval = max(interval, PULSE_LEN+1); eff_frames = (num_frames==0) ? 1 : num_frames.
- States:
  - IDLE: on edge and !abort → PULSE. Clear frame_count to 1, set busy, reset the period counter to 0.
  - PULSE: FRAME_REQ=1. The period counter increments each cycle. After PULSE_LEN cycles → WAIT.
  - WAIT: FRAME_REQ=0. The period counter continues.
    - Burst with frame_count==eff_frames: entering WAIT instead goes to DONE.
    - At count eff_interval-1 with more frames needed (or continuous mode): → PULSE. Counter resets to 0, frame_count +1.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- abort:
  - In PULSE: the current pulse is never truncated. On completion → IDLE with busy=0 and no done.
  - In WAIT: → IDLE next cycle, busy=0, no done.
  - In IDLE: inhibits a same-cycle edge (abort wins).
- Trigger edges while busy are ignored. A new run needs a fresh rising edge after returning to IDLE.
- frame_count saturates at 2^CNT_W-1 in continuous mode; pulses continue. It holds its value in IDLE until the next run start.
- Reset asserted mid-pulse drops FRAME_REQ immediately (asynchronous clear).

## Timing
- Start latency: trigger rising before FSM_Clk edge k (setup met) → FRAME_REQ rises after edge k+SYNC_STAGES+1. busy rises the same edge.
- FRAME_REQ high exactly PULSE_LEN cycles. Rising-edge spacing is exactly eff_interval cycles.
- Burst end: done high during the cycle immediately after FRAME_REQ falls on the last frame. busy falls at that same edge.
- Earliest restart: a trigger edge detected in the cycle after DONE is accepted.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Single frame: mode=0, num_frames=1, interval=10, trigger 0→1. Required: one 4-cycle FRAME_REQ pulse SYNC_STAGES+1 cycles after trigger, then done one cycle after it falls, and frame_count=1.
- Burst: num_frames=5, interval=20. Required: five pulses with rising edges exactly 20 cycles apart, frame_count 1..5, one done pulse, busy high from first rise to done.
- Interval clamp / zero count: num_frames=0, interval=2. Required: exactly one pulse. Then num_frames=3, interval=2: pulses spaced 5 cycles (PULSE_LEN+1).
- Continuous + abort: mode=1, interval=8. Assert abort mid-pulse on frame 6. Required: pulse completes its full 4 cycles, then IDLE, busy=0, no done, frame_count=6.
- Retrigger/abort precedence: trigger toggled during a burst is ignored. Abort asserted in the same cycle as the edge detection in IDLE means no run starts.
- Reset mid-run: assert reset during PULSE. Required: FRAME_REQ, busy and frame_count go to 0 without waiting for a clock edge, and no pulses follow after reset release until a new trigger edge.
